mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the pipelined MIPS core: the initiator side of the data-memory interface. It turns the stage's load/store request into a handshaked bus transaction with byte enables, and stalls the pipeline until the memory acknowledges. It returns sign- or zero-extended load data, flags misaligned or timed-out accesses, and sits between the EX/MEM pipeline register and a wait-stated data memory.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles in BUSY without `mem_ack` before abort (1..255).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: MEM stage holds a load or store; held stable while `stall`=1.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `req_unsigned` in 1: zero-extend the load (lbu/lhu).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `stall` out 1: freeze PC and IF/ID, ID/EX, EX/MEM registers.
- `ld_valid` out 1: one-cycle pulse, `ld_data` valid.
- `ld_data` out 32: extended load result.
- `err` out 1: one-cycle pulse, access failed.
- `err_code` out 2: 01 misaligned, 10 timeout; 00 otherwise.
- `mem_req` out 1: bus request.
- `mem_we` out 1: write.
- `mem_be` out 4: byte enables, bit i = byte lane i.
- `mem_adr` out 32: word address, `{req_addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory completes the request this cycle.
- `mem_rdata` in 32: read word, valid when `mem_ack`=1.

## Operation
- Little-endian; lane = `addr[1:0]`.
- FSM states:
  - IDLE: on `req_valid`, latch request, go BUSY.
  - BUSY: `mem_req`=1, bus outputs registered and stable. On `mem_ack`, capture data and go RESP. On counter = `TIMEOUT_CYCLES`, go RESP with timeout.
  - RESP: pulse `ld_valid` (load, no error) or `err`, then go IDLE.
- RESP never issues a new request. The same instruction is still presented; the pipeline advances on this edge.
- `stall` = (IDLE & `req_valid`) | BUSY. It is 0 in RESP.
- Stores:
  - Byte: `mem_wdata`={4{wdata[7:0]}}, `mem_be`=1<<lane.
  - Half: `mem_wdata`={2{wdata[15:0]}}, `mem_be`=0011 or 1100.
  - Word: `mem_be`=1111.
- Loads: `mem_be` as for stores, `mem_we`=0. Select the lane byte or half from `mem_rdata`. Sign-extend unless `req_unsigned`; word loads pass through.
- Misaligned: half with `addr[0]`=1; word with `addr[1:0]`≠0.
- Timeout: drop `mem_req`, `err`=1, `err_code`=10, `ld_data`=0, no `ld_valid`. If `mem_ack` arrives in the timeout cycle, ack wins and the access completes normally.
- Reset values (async `rst_n`=0, including mid-transaction): state IDLE, counter 0, every output 0, bus request dropped immediately.
- `ld_data` holds its last value until the next load completes.

## Timing
- Minimum latency 3 cycles: request cycle (IDLE, stall=1), BUSY with ack, RESP.
- Each extra wait cycle adds one BUSY cycle.
- `mem_ack` is sampled only in BUSY and ignored elsewhere.
- `mem_rdata` is captured on the ack edge; `ld_data` is valid in RESP.
- Back-to-back accesses: RESP, then IDLE with the next instruction; at most one request per 3 cycles.
- Timeout RESP occurs at BUSY cycle `TIMEOUT_CYCLES`+1.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned request issues no bus cycle. Next cycle is RESP with `err`=1, `err_code`=01, `ld_valid`=0. `stall`=1 for exactly one cycle.
- Undefined: the address is forced to natural alignment (`addr[0]` cleared for half, `addr[1:0]` cleared for word), the access proceeds normally, and `err_code` 01 never occurs.

## Structure
- Shared package `mips_lsu_pkg` holds:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
  - FSM state encodings
  - error codes
  - timeout counter width (8)
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension, reused by any future cache path.
- The FSM, byte-enable/replication logic and counter live in `mem_stage_lsu`.

## Test plan
- **Word load:** addr 0x100, memory returns 0xDEADBEEF with ack in first BUSY cycle → stall 1,1,0; `ld_valid` on cycle 3 with `ld_data`=0xDEADBEEF.
- **Byte store:** sb addr 0x203, wdata 0x000000A5 → `mem_adr`=0x200, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_we`=1, no `ld_valid`.
- **Half loads:** mem word 0x80F0_1234. lh at lane 2 → 0xFFFF80F0; lhu at lane 2 → 0x000080F0; lb at lane 0 → 0x00000034.
- **Wait states and timeout:** ack after 4 wait cycles → 6-cycle stall window. With `TIMEOUT_CYCLES`=8 and no ack → `err`=1, `err_code`=10 at BUSY cycle 9, `mem_req` dropped. Ack on the 8th BUSY cycle → normal completion.
- **Misaligned:** lw at 0x102. With `LSU_MISALIGN_TRAP_EN` → no `mem_req`, `err_code`=01 next cycle. Without it → `mem_adr`=0x100, normal load.
- **Reset mid-transaction:** `rst_n` low during BUSY → `mem_req`, `stall`, `ld_valid`, `err` go 0 asynchronously. After release, a new request starts cleanly from IDLE.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states,
// error codes and the timeout counter width.
package mips_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StResp = 2'b10
    } state_e;

    // Size code 11 behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_WORD : size;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half lane from a read word
// and sign- or zero-extends it; word loads pass through.
module lsu_load_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (lane)
            2'd0:    lane_byte = rdata[7:0];
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            default: lane_byte = rdata[31:24];
        endcase
        lane_half = lane[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: data = {{24{lane_byte[7] & ~is_unsigned}}, lane_byte};
            SZ_HALF: data = {{16{lane_half[15] & ~is_unsigned}}, lane_half};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: handshaked data-memory initiator with stall, byte
// enables, load extension and timeout. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_stage_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, uns_q;
    logic [1:0]       size_q, lane_q;
    logic [3:0]       be_q;
    logic [31:0]      adr_q, wdata_q, ld_data_q;
    logic             ld_valid_q, err_q;
    logic [1:0]       err_code_q;

    logic [1:0]  size_n, lane_n;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, ld_aligned;
    logic        accept, trap, done_ack, done_to;

    // Request decode; the lane is forced to natural alignment for half/word.
    always_comb begin
        size_n = norm_size(req_size);
        unique case (size_n)
            SZ_BYTE: begin
                lane_n  = req_addr[1:0];
                be_n    = 4'b0001 << req_addr[1:0];
                wdata_n = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_n  = {req_addr[1], 1'b0};
                be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_n  = 2'b00;
                be_n    = 4'b1111;
                wdata_n = req_wdata;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        trap     = 1'b0;
        done_ack = 1'b0;
        done_to  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if ((size_n == SZ_HALF && req_addr[0]) ||
                        (size_n == SZ_WORD && req_addr[1:0] != 2'b00)) begin
                        trap    = 1'b1;
                        state_d = StResp;
                    end else begin
                        accept  = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = StBusy;
                    end
`else
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = StBusy;
`endif
                end
            end
            StBusy: begin
                // cnt_q numbers the current BUSY cycle; ack beats timeout.
                if (mem_ack) begin
                    done_ack = 1'b1;
                    cnt_d    = '0;
                    state_d  = StResp;
                end else if (cnt_q == TimeoutCnt) begin
                    done_to = 1'b1;
                    cnt_d   = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rdata       (mem_rdata),
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .data        (ld_aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            lane_q     <= 2'b00;
            be_q       <= 4'b0000;
            adr_q      <= '0;
            wdata_q    <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_valid_q <= done_ack & ~we_q;
            err_q      <= done_to | trap;
            err_code_q <= done_to ? ERR_TIMEOUT : (trap ? ERR_MISALIGN : ERR_NONE);
            if (accept) begin
                we_q    <= req_write;
                uns_q   <= req_unsigned;
                size_q  <= size_n;
                lane_q  <= lane_n;
                be_q    <= be_n;
                adr_q   <= {req_addr[31:2], 2'b00};
                wdata_q <= wdata_n;
            end
            if (done_ack && !we_q) begin
                ld_data_q <= ld_aligned;
            end else if (done_to) begin
                ld_data_q <= '0;
            end
        end
    end

    // Gated by rst_n so the pipeline sees no stall while reset is asserted.
    assign stall     = rst_n & (((state_q == StIdle) & req_valid) | (state_q == StBusy));
    assign mem_req   = (state_q == StBusy);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_adr   = adr_q;
    assign mem_wdata = wdata_q;
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized accesses
// checked cycle by cycle against a behavioural memory-access model.
module tb_mem_stage_lsu;

    localparam int unsigned T_CYC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, ld_valid, err, mem_req, mem_we, mem_ack;
    logic [31:0] ld_data, mem_adr, mem_wdata, mem_rdata;
    logic [1:0]  err_code;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] last_ld = '0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(T_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .err          (err),
        .err_code     (err_code),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One complete access; waits = BUSY cycles before the ack cycle.
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int waits, input logic [31:0] word);
        longint unsigned nbytes, lane, mask, v;
        logic [31:0] exp_be, exp_wd, exp_ld;
        bit mis, trap, acked;
        nbytes = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        mis    = (addr % nbytes) != 0;
        lane   = ((addr % 4) / nbytes) * nbytes;
        exp_be = 32'(((64'd1 << nbytes) - 1) << lane);
        if (nbytes == 1)      exp_wd = (wd & 32'hFF) * 32'h0101_0101;
        else if (nbytes == 2) exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        else                  exp_wd = wd;
        mask = (64'd1 << (8 * nbytes)) - 1;
        v    = (64'(word) >> (8 * lane)) & mask;
        if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (64'hFFFF_FFFF & ~mask);
        exp_ld = 32'(v);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = mis;
`else
        trap = 1'b0;
`endif
        acked = 1'b0;

        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        mem_ack = 1'(($urandom % 2)); mem_rdata = $urandom;
        #1;
        check_eq("req_stall", stall, 1);
        check_eq("req_mem_req", mem_req, 0);
        check_eq("req_ld_valid", ld_valid, 0);
        check_eq("req_err", err, 0);

        if (!trap) begin
            for (int n = 1; n <= int'(T_CYC); n++) begin
                @(negedge clk);
                if (n == waits + 1) begin
                    mem_ack = 1'b1; mem_rdata = word;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
                #1;
                check_eq("busy_mem_req", mem_req, 1);
                check_eq("busy_stall", stall, 1);
                if (n == 1) begin
                    check_eq("mem_adr", mem_adr, {addr[31:2], 2'b00});
                    check_eq("mem_be", 32'(mem_be), exp_be);
                    check_eq("mem_we", mem_we, wr);
                    if (wr) check_eq("mem_wdata", mem_wdata, exp_wd);
                end
                if (n == waits + 1) begin
                    acked = 1'b1;
                    break;
                end
            end
        end

        @(negedge clk);
        mem_ack = 1'(($urandom % 2)); mem_rdata = $urandom;
        #1;
        check_eq("resp_stall", stall, 0);
        check_eq("resp_mem_req", mem_req, 0);
        if (trap) begin
            check_eq("trap_err", err, 1);
            check_eq("trap_code", err_code, 2'b01);
            check_eq("trap_ld_valid", ld_valid, 0);
            check_eq("trap_ld_data", ld_data, last_ld);
        end else if (!acked) begin
            last_ld = '0;
            check_eq("to_err", err, 1);
            check_eq("to_code", err_code, 2'b10);
            check_eq("to_ld_valid", ld_valid, 0);
            check_eq("to_ld_data", ld_data, 0);
        end else begin
            if (!wr) last_ld = exp_ld;
            check_eq("ok_err", err, 0);
            check_eq("ok_code", err_code, 0);
            check_eq("ok_ld_valid", ld_valid, !wr);
            check_eq("ok_ld_data", ld_data, last_ld);
        end
        req_valid = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_ld_valid", ld_valid, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_err_code", err_code, 0);
        check_eq("rst_ld_data", ld_data, 0);
        check_eq("rst_mem_be", 32'(mem_be), 0);
        check_eq("rst_mem_adr", mem_adr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_00A5, 0, 32'h0);
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h80F0_1234);
        run_access(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 0, 32'h80F0_1234);
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h80F0_1234);
        run_access(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h1234_5678, 0, 32'h0);
        run_access(1'b0, 2'b11, 1'b0, 32'h0000_0104, 32'h0, 4, 32'hCAFE_F00D);
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0108, 32'h0, 20, 32'h1111_2222);
        run_access(1'b1, 2'b01, 1'b0, 32'h0000_010E, 32'hABCD_9876, 0, 32'h0);
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_010C, 32'h0, int'(T_CYC) - 1, 32'h7777_8888);
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h5555_AAAA);
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0, 0, 32'hFEDC_BA98);

        // Asynchronous reset while BUSY
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h300; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 check_eq("pre_rst_mem_req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_mem_req", mem_req, 0);
        check_eq("arst_stall", stall, 0);
        check_eq("arst_ld_valid", ld_valid, 0);
        check_eq("arst_err", err, 0);
        check_eq("arst_ld_data", ld_data, 0);
        last_ld = '0;
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0;
        run_access(1'b0, 2'b00, 1'b1, 32'h0000_0301, 32'h0, 2, 32'h0000_F100);

        // Randomized accesses, including back-to-back and timeouts
        for (int i = 0; i < 60; i++) begin
            run_access(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), $urandom,
                       $urandom, int'($urandom_range(0, 10)), $urandom);
            if ($urandom % 3 == 0) begin
                @(negedge clk);
                mem_ack = 1'($urandom % 2);
                #1 check_eq("idle_stall", stall, 0);
                check_eq("idle_mem_req", mem_req, 0);
                mem_ack = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
